serial_mag_comp_ctrl: RTL and testbench
=======================================

Name: serial_mag_comp_ctrl

Overview:
- Sequencer that compares two WIDTH-bit unsigned operands with a single instance of the team's two-bit comparator cell (two_bit_comp), MSB slice first, one 2-bit slice per clock.
- Latches the operands on a start request and walks a slice index down from the top slice.
- Keeps a sticky greater/less decision and reports registered G/L/E with a one-cycle done pulse.
- Sits between the control unit and the ALU flag path, so one comparator cell serves any operand width.

Parameters:
- WIDTH, 8: operand width in bits. Must be even and at least 2. NSLICE = WIDTH/2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a compare. Accepted only when busy=0.
- a  input  WIDTH  operand A, sampled on the accepting edge only.
- b  input  WIDTH  operand B, sampled on the accepting edge only.
- busy  output  1  high while a comparison is in progress.
- done  output  1  one-cycle pulse; G/L/E are valid and new.
- G  output  1  registered result: A>B.
- L  output  1  registered result: A<B.
- E  output  1  registered result: A==B.

Behaviour:
- Reset values: busy=0, done=0, G=0, L=0, E=0; state=IDLE; slice index and decision cleared. Reset wins over every other input on the same edge.
- Reset mid-operation: abort on that edge, return to the reset values. No done pulse is issued for the aborted compare.
- State machine has two states, IDLE and CMP.
- IDLE, start=1 at edge t0:
  - latch a and b;
  - set idx=NSLICE-1 and clear the decision;
  - go to CMP; busy=1 after t0.
- IDLE, start=0: hold state; G/L/E keep their last result.
- CMP, each edge: the comparator cell sees slice [2*idx+1:2*idx] of the latched operands.
  - If no decision is held and the cell reports G or L, record that result as the decision.
  - A recorded decision is never overwritten by later slices.
- CMP terminates on the edge where idx==0, or where a decision is recorded if the early-exit feature is compiled in. On that edge:
  - G/L are loaded from the decision (including the current slice);
  - E = 1 only if no slice was unequal;
  - done=1 and busy=0; next state is IDLE.
- Exactly one of G/L/E is 1 after any completed compare.
- Latency without early exit: done is high in the cycle after edge t0+NSLICE.
- done lasts exactly one cycle. G/L/E hold until the next completed compare.
- start while busy=1 is ignored and not queued. Operand changes during CMP have no effect.
- start during the done cycle is accepted, because busy=0 then. This gives back-to-back operation with no idle bubble.
- a/b are sampled only on the accepting edge.

Optional Feature:
- Macro: SERIAL_COMP_EARLY_EXIT_EN.
- Defined: CMP terminates on the first edge whose slice is unequal. Latency is j edges after t0, where j is the 1-based slice position counted from the MSB. Equal operands still take NSLICE edges.
- Undefined: every compare takes exactly NSLICE edges regardless of data. G/L/E values are identical in both builds.

Test Plan:
- Reset, then a=8'hA5, b=8'hA5, start for one cycle (WIDTH=8) -> busy for 4 cycles; done pulse after edge t0+4; G=0, L=0, E=1; both builds.
- a=8'h80, b=8'h7F -> G=1, L=0, E=0. done after edge t0+1 with SERIAL_COMP_EARLY_EXIT_EN defined, after edge t0+4 without it.
- a=8'h12, b=8'h13 -> L=1, G=0, E=0; done after edge t0+4 in both builds. Checks a decision in the last slice.
- Compare 8'h10 vs 8'h20:
  - drive start=1 with a=8'hFF, b=8'h00 while busy -> ignored; the first compare finishes with L=1;
  - then start in the done cycle with a=8'h03, b=8'h01 -> accepted; G=1 after edge 4 (no early exit).
- Start a=8'h01, b=8'h02, assert reset at edge t0+2 -> next cycle busy=0, done=0, G=L=E=0; no done pulse follows.
- After any compare, hold start=0 for 10 cycles -> G/L/E unchanged, done stays 0.

Source files
------------

// File: rtl/serial_mag_comp_ctrl_if.sv
// Start/operand/result bundle for serial_mag_comp_ctrl.
// The control unit drives the master side and the comparator sequencer is the slave.
interface serial_mag_comp_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             G;
  logic             L;
  logic             E;

  modport master (
    output start, a, b,
    input  busy, done, G, L, E
  );

  modport slave (
    input  start, a, b,
    output busy, done, G, L, E
  );
endinterface

// File: rtl/serial_mag_comp_ctrl.sv
// Serial unsigned magnitude comparator: one two_bit_comp cell walks the operands MSB slice first.
// Optional macro SERIAL_COMP_EARLY_EXIT_EN ends the compare on the first unequal slice.

module two_bit_comp (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       g,
  output logic       l,
  output logic       e
);
  always_comb begin
    g = (a > b);
    l = (a < b);
    e = (a == b);
  end
endmodule

module serial_mag_comp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  serial_mag_comp_ctrl_if.slave bus
);
  localparam int NSLICE = WIDTH / 2;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CMP  = 1'b1;

  logic [0:0]       state;
  logic [IDXW-1:0]  idx_p1;
  logic             dec_vld_p1;
  logic             dec_g_p1;
  logic             done_r;
  logic             g_r;
  logic             l_r;
  logic             e_r;

  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;

  logic [1:0]       slice_a;
  logic [1:0]       slice_b;
  logic             c_g;
  logic             c_l;
  logic             c_e;
  logic             fin_g;
  logic             fin_l;
  logic             last_slice;
  logic             term;
  logic             accept;

  // Stage p0: operand capture on the accepting edge only
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0 <= bus.a;
      b_p0 <= bus.b;
    end
  end

  // Stage p1: one slice per cycle through the shared comparator cell
  always_comb begin
    slice_a = a_p0[{idx_p1, 1'b0} +: 2];
    slice_b = b_p0[{idx_p1, 1'b0} +: 2];
  end

  two_bit_comp u_cell (
    .a (slice_a),
    .b (slice_b),
    .g (c_g),
    .l (c_l),
    .e (c_e)
  );

  // A held decision always wins over the current slice
  always_comb begin
    fin_g      = dec_vld_p1 ? dec_g_p1  : c_g;
    fin_l      = dec_vld_p1 ? ~dec_g_p1 : c_l;
    last_slice = (idx_p1 == '0);
    accept     = (state == IDLE) && bus.start;
`ifdef SERIAL_COMP_EARLY_EXIT_EN
    term       = last_slice || !c_e;
`else
    term       = last_slice;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx_p1     <= '0;
      dec_vld_p1 <= 1'b0;
      dec_g_p1   <= 1'b0;
      done_r     <= 1'b0;
      g_r        <= 1'b0;
      l_r        <= 1'b0;
      e_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= CMP;
            idx_p1     <= IDXW'(NSLICE - 1);
            dec_vld_p1 <= 1'b0;
            dec_g_p1   <= 1'b0;
          end
        end
        CMP: begin
          if (term) begin
            state  <= IDLE;
            done_r <= 1'b1;
            g_r    <= fin_g;
            l_r    <= fin_l;
            e_r    <= ~(fin_g | fin_l);
          end else begin
            idx_p1 <= idx_p1 - 1'b1;
            if (!dec_vld_p1 && !c_e) begin
              dec_vld_p1 <= 1'b1;
              dec_g_p1   <= c_g;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage p2: registered results to the flag path
  always_comb begin
    bus.busy = (state == CMP);
    bus.done = done_r;
    bus.G    = g_r;
    bus.L    = l_r;
    bus.E    = e_r;
  end
endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// Directed and randomized bench for serial_mag_comp_ctrl against an arithmetic reference model.
// Works in both builds; the expected latency follows SERIAL_COMP_EARLY_EXIT_EN.
module tb_serial_mag_comp_ctrl;
  localparam int W  = 8;
  localparam int NS = W / 2;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   errs    = 0;

  serial_mag_comp_ctrl_if #(.WIDTH(W)) bus ();

  serial_mag_comp_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic exp_g, exp_l, exp_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: result from plain integer comparison; latency from the first differing 2-bit digit
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat);
    int first;
    exp_g = (av > bv);
    exp_l = (av < bv);
    exp_e = (av == bv);
    first = NS;
    for (int j = NS; j >= 1; j--)
      if (((av >> (W - 2 * j)) & 3) != ((bv >> (W - 2 * j)) & 3)) first = j;
`ifdef SERIAL_COMP_EARLY_EXIT_EN
    lat = first;
`else
    lat = NS;
`endif
  endtask

  // Called just after an edge with busy low; returns just after the accepting edge t0
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_accept", bus.busy, 1);
  endtask

  // Waits for done after t0, scrambling the live operands to show they are ignored
  task automatic finish(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
    int lat, k;
    model(av, bv, lat);
    k = 0;
    while (k < lat + 4) begin
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      @(posedge clk); #1;
      k++;
      if (bus.done) break;
      if (k < lat) chk({tag, "_busy_mid"}, bus.busy, 1);
    end
    chk({tag, "_latency"}, k, lat);
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_busy_done"}, bus.busy, 0);
    chk({tag, "_GLE"}, {bus.G, bus.L, bus.E}, {exp_g, exp_l, exp_e});
  endtask

  task automatic compare(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
    issue(av, bv);
    finish(tag, av, bv);
  endtask

  initial begin
    int lat;
    logic [W-1:0] ra, rb;
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.a     = '1;
    bus.b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {bus.busy, bus.done, bus.G, bus.L, bus.E}, 5'b0);
    bus.start = 1'b0;
    reset     = 1'b0;
    @(posedge clk); #1;

    compare("eq_a5", 8'hA5, 8'hA5);
    compare("gt_msb", 8'h80, 8'h7F);
    compare("lt_lsb", 8'h12, 8'h13);

    // Start held high while busy is ignored; start in the done cycle is taken
    issue(8'h10, 8'h20);
    bus.start = 1'b1;
    finish("busy_ignore", 8'h10, 8'h20);
    compare("back_to_back", 8'h03, 8'h01);

    // Hold: results stay, done stays low
    model(8'h03, 8'h01, lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold", {bus.done, bus.G, bus.L, bus.E}, {1'b0, exp_g, exp_l, exp_e});
    end

    // Reset two edges into a compare aborts it
    issue(8'h01, 8'h02);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_state", {bus.busy, bus.done, bus.G, bus.L, bus.E}, 5'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort_no_done", {bus.busy, bus.done}, 2'b00);
    end

    // Random operands, biased toward near-equal pairs to reach the low slices
    for (int n = 0; n < 60; n++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ W'(1 << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
      compare("random", ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
